mem_port_arbiter: RTL and testbench

- Shares the single-ported unified instruction/data memory between two requesters of the multi-cycle core: the instruction-fetch path (IF) and the load/store path (D).
- Arbitrates between simultaneous requests with a round-robin policy.
- Registers the winning request onto a valid/ready memory handshake and returns one ack pulse with read data.
- A watchdog counter aborts accesses the memory never completes.

---
 rtl/mem_port_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter sharing one memory port between fetch and data paths
// Registers the winner onto a valid/ready memory handshake, with a watchdog that aborts stalled accesses.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_valid,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              err,
    output logic              busy
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_owner;     // 0 = fetch, 1 = data
    logic              r_last;      // last granted requester, same encoding as r_owner
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_d_rdata;
    logic              r_err;
    logic [CNT_W-1:0]  r_cnt;

    logic w_any_req;
    logic w_pick_d;
    logic w_timeout;

    assign w_any_req = if_req | d_req;
    // On a tie the requester that did not win last time gets the port.
    assign w_pick_d  = d_req & (~if_req | ~r_last);
    assign w_timeout = (r_cnt == CNT_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_any_req) w_next = ST_ACCESS;
            ST_ACCESS: if (mem_ready || w_timeout) w_next = ST_RESP;
            ST_RESP:   w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_owner    <= 1'b0;
            r_last     <= 1'b1;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_if_rdata <= '0;
            r_d_rdata  <= '0;
            r_err      <= 1'b0;
            r_cnt      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_owner <= w_pick_d;
                        r_last  <= w_pick_d;
                        r_addr  <= w_pick_d ? d_addr : if_addr;
                        r_we    <= w_pick_d & d_we;
                        r_wdata <= w_pick_d ? d_wdata : '0;
                        r_cnt   <= '0;
                    end
                end
                ST_ACCESS: begin
                    if (mem_ready) begin
                        r_err <= 1'b0;
                        if (r_owner) r_d_rdata  <= r_we ? '0 : mem_rdata;
                        else         r_if_rdata <= mem_rdata;
                    end else if (w_timeout) begin
                        r_err <= 1'b1;
                        if (r_owner) r_d_rdata  <= '0;
                        else         r_if_rdata <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_valid = (r_state == ST_ACCESS);
    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign if_ack    = (r_state == ST_RESP) & ~r_owner;
    assign d_ack     = (r_state == ST_RESP) & r_owner;
    assign err       = (r_state == ST_RESP) & r_err;
    assign busy      = (r_state != ST_IDLE);
    assign if_rdata  = r_if_rdata;
    assign d_rdata   = r_d_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
// Transaction-level model: grant order from last-grant, access length from memory delay.
module tb_mem_port_arbiter;

    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        mem_valid;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        err;
    logic        busy;

    int total = 0;
    int bad   = 0;
    int m_last;   // 0 = fetch, 1 = data; last granted requester in the model

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Entered and left 1 time unit after a rising edge, with the arbiter idle.
    task automatic run_round(input bit en_if, input bit en_d,
                             input logic [31:0] a_if, input logic [31:0] a_d,
                             input bit we_d, input logic [31:0] wd_d,
                             input int dly_if, input int dly_d,
                             input logic [31:0] rd_if, input logic [31:0] rd_d,
                             input bit scramble);
        int order[2];
        int n;
        int owner;
        int dly;
        int ncyc;
        bit tmo;
        logic [31:0] e_addr, e_wd, rd, e_rd;
        logic e_we;
        n = 0;
        if (en_if && en_d) begin
            order[0] = (m_last == 1) ? 0 : 1;
            order[1] = 1 - order[0];
            n = 2;
        end else if (en_if) begin
            order[0] = 0; n = 1;
        end else if (en_d) begin
            order[0] = 1; n = 1;
        end
        if_req = en_if; if_addr = a_if;
        d_req = en_d; d_we = we_d; d_addr = a_d; d_wdata = wd_d;
        mem_ready = 1'b0;
        step();
        for (int t = 0; t < n; t++) begin
            owner  = order[t];
            m_last = owner;
            e_addr = (owner == 1) ? a_d : a_if;
            e_we   = (owner == 1) ? we_d : 1'b0;
            e_wd   = (owner == 1) ? wd_d : 32'h0;
            dly    = (owner == 1) ? dly_d : dly_if;
            rd     = (owner == 1) ? rd_d : rd_if;
            tmo    = (dly >= TIMEOUT);
            ncyc   = tmo ? TIMEOUT : dly + 1;
            e_rd   = (tmo || e_we) ? 32'h0 : rd;
            for (int k = 0; k < ncyc; k++) begin
                if (scramble) begin
                    if_addr = ~a_if; d_addr = a_d ^ 32'h30; d_wdata = ~wd_d; d_we = ~we_d;
                end
                if (!tmo && k == ncyc - 1) begin
                    mem_ready = 1'b1; mem_rdata = rd;
                end else begin
                    mem_ready = 1'b0; mem_rdata = $urandom;
                end
                @(negedge clk);
                total++; if (mem_valid !== 1'b1) begin bad++; $display("FAIL access_valid owner=%0d cyc=%0d got=%b exp=1", owner, k, mem_valid); end
                total++; if (mem_addr !== e_addr) begin bad++; $display("FAIL access_addr owner=%0d cyc=%0d got=%h exp=%h", owner, k, mem_addr, e_addr); end
                total++; if (mem_we !== e_we) begin bad++; $display("FAIL access_we owner=%0d cyc=%0d got=%b exp=%b", owner, k, mem_we, e_we); end
                if (e_we) begin
                    total++; if (mem_wdata !== e_wd) begin bad++; $display("FAIL access_wdata cyc=%0d got=%h exp=%h", k, mem_wdata, e_wd); end
                end
                total++; if ({if_ack, d_ack} !== 2'b00) begin bad++; $display("FAIL access_noack cyc=%0d got=%b%b exp=00", k, if_ack, d_ack); end
                total++; if (busy !== 1'b1) begin bad++; $display("FAIL access_busy cyc=%0d got=%b exp=1", k, busy); end
                step();
            end
            mem_ready = 1'b0;
            if_addr = a_if; d_addr = a_d; d_wdata = wd_d; d_we = we_d;
            @(negedge clk);
            total++; if (mem_valid !== 1'b0) begin bad++; $display("FAIL resp_valid got=%b exp=0", mem_valid); end
            total++; if (if_ack !== (owner == 0)) begin bad++; $display("FAIL resp_if_ack owner=%0d got=%b exp=%b", owner, if_ack, owner == 0); end
            total++; if (d_ack !== (owner == 1)) begin bad++; $display("FAIL resp_d_ack owner=%0d got=%b exp=%b", owner, d_ack, owner == 1); end
            total++; if (err !== tmo) begin bad++; $display("FAIL resp_err owner=%0d got=%b exp=%b", owner, err, tmo); end
            if (owner == 0) begin
                total++; if (if_rdata !== e_rd) begin bad++; $display("FAIL resp_if_rdata got=%h exp=%h", if_rdata, e_rd); end
            end else begin
                total++; if (d_rdata !== e_rd) begin bad++; $display("FAIL resp_d_rdata got=%h exp=%h", d_rdata, e_rd); end
            end
            step();
            if (owner == 0) if_req = 1'b0; else d_req = 1'b0;
            @(negedge clk);
            total++; if ({busy, mem_valid, if_ack, d_ack, err} !== 5'b0) begin bad++; $display("FAIL idle_gap got busy=%b valid=%b acks=%b%b err=%b exp=all 0", busy, mem_valid, if_ack, d_ack, err); end
            total++; if (((owner == 0) ? if_rdata : d_rdata) !== e_rd) begin bad++; $display("FAIL rdata_hold owner=%0d got=%h exp=%h", owner, (owner == 0) ? if_rdata : d_rdata, e_rd); end
            step();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        mem_ready = 0; mem_rdata = 0;
        repeat (3) step();
        @(negedge clk);
        total++; if ({if_ack, d_ack, err, mem_valid, mem_we, busy} !== 6'b0) begin bad++; $display("FAIL reset_ctrl got=%b exp=000000", {if_ack, d_ack, err, mem_valid, mem_we, busy}); end
        total++; if ({mem_addr, mem_wdata, if_rdata, d_rdata} !== 128'h0) begin bad++; $display("FAIL reset_data got=%h %h %h %h exp=0", mem_addr, mem_wdata, if_rdata, d_rdata); end
        step();
        reset = 1'b0;
        m_last = 1;
        step();
    endtask

    task automatic test_if_only();
        run_round(1, 0, 32'h100, 32'h0, 0, 32'h0, 0, 0, 32'h13, 32'h0, 0);
    endtask

    task automatic test_store();
        run_round(0, 1, 32'h0, 32'h2000, 1, 32'hDEADBEEF, 0, 2, 32'h0, 32'h55AA55AA, 0);
    endtask

    task automatic test_tie();
        run_round(1, 1, 32'h400, 32'h800, 0, 32'h0, 0, 0, 32'h11111111, 32'h22222222, 0);
        run_round(1, 1, 32'h404, 32'h804, 1, 32'h33, 0, 0, 32'h44444444, 32'h55555555, 0);
    endtask

    task automatic test_timeout();
        run_round(0, 1, 32'h0, 32'h40, 0, 32'h0, 0, TIMEOUT, 32'h0, 32'hFFFFFFFF, 0);
        run_round(0, 1, 32'h0, 32'h44, 0, 32'h0, 0, 1, 32'h0, 32'hCAFEF00D, 0);
    endtask

    task automatic test_reset_in_access();
        if_req = 1'b1; if_addr = 32'h300; mem_ready = 1'b0;
        step();
        step();
        reset = 1'b1;
        @(negedge clk);
        total++; if (mem_valid !== 1'b1) begin bad++; $display("FAIL rst_acc_pre got=%b exp=1", mem_valid); end
        step();
        reset = 1'b0; if_req = 1'b0;
        @(negedge clk);
        total++; if ({mem_valid, busy, if_ack, d_ack} !== 4'b0) begin bad++; $display("FAIL rst_acc_post got=%b exp=0000", {mem_valid, busy, if_ack, d_ack}); end
        total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL rst_acc_addr got=%h exp=0", mem_addr); end
        step();
        @(negedge clk);
        total++; if ({if_ack, busy} !== 2'b00) begin bad++; $display("FAIL rst_acc_noack got=%b exp=00", {if_ack, busy}); end
        step();
        m_last = 1;
        run_round(1, 1, 32'h500, 32'h600, 0, 32'h0, 1, 0, 32'h77, 32'h88, 0);
    endtask

    task automatic test_mid_access_change();
        run_round(0, 1, 32'h0, 32'h10, 1, 32'h12345678, 0, 3, 32'h0, 32'h0, 1);
        run_round(1, 1, 32'h10, 32'h10, 0, 32'h0, 2, 1, 32'h9ABCDEF0, 32'h0F0F0F0F, 1);
    endtask

    task automatic test_random();
        bit ei, ed;
        for (int r = 0; r < 40; r++) begin
            ei = $urandom_range(0, 1);
            ed = $urandom_range(0, 1);
            if (!ei && !ed) ei = 1'b1;
            run_round(ei, ed, $urandom, $urandom, 1'($urandom_range(0, 1)), $urandom,
                      $urandom_range(0, 4), $urandom_range(0, 4), $urandom, $urandom,
                      1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_if_only();
        test_store();
        test_tie();
        test_timeout();
        test_reset_in_access();
        test_mid_access_change();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
